// File: rtl/sample_packer_if.sv
// Handshake bundle for sample_packer: quantised samples in, packed words out.
interface sample_packer_if #(
    parameter int NCH   = 4,
    parameter int SBITS = 2,
    parameter int OUT_W = 16
);
    logic [NCH*2*SBITS-1:0] in_data;
    logic                   in_valid;
    logic [OUT_W-1:0]       out_data;
    logic                   out_valid;
    logic                   out_ready;

    // master is the surrounding environment (quantizers and packet_streamer), slave is the packer
    modport master (output in_data, in_valid, out_ready, input out_data, out_valid);
    modport slave  (input in_data, in_valid, out_ready, output out_data, out_valid);
endinterface

// File: rtl/sample_packer.sv
// Keeps the first nch_active channels of every (decim+1)-th sample, packs them MSB-first
// into OUT_W-bit words and queues the words in a DEPTH-entry FIFO with overflow counting.
module sample_packer #(
    parameter int NCH   = 4,
    parameter int SBITS = 2,
    parameter int OUT_W = 16,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    sample_packer_if.slave         bus,
    input  logic [3:0]             nch_active,
    input  logic [3:0]             decim,
    input  logic                   ovf_clear,
    output logic [15:0]            ovf_count,
    output logic [$clog2(DEPTH):0] fill_level
);
    localparam int KMAX  = NCH * 2 * SBITS;
    localparam int ACC_W = 2 * OUT_W;
    localparam int FW    = $clog2(ACC_W + 1);
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;

    logic [3:0]       r_nch;
    logic [3:0]       r_decim;
    logic [3:0]       r_dcnt;
    logic [ACC_W-1:0] r_acc;
    logic [FW-1:0]    r_fill;
    logic             r_pend_v;
    logic [OUT_W-1:0] r_pend_w;
    logic [OUT_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_count;
    logic             r_out_valid;
    logic [15:0]      r_ovf;

    logic             w_cfg_change;
    logic [3:0]       w_n;
    logic [FW-1:0]    w_k;
    logic             w_keep;
    logic [ACC_W-1:0] w_samp;
    logic [ACC_W-1:0] w_merged;
    logic [FW-1:0]    w_sum;
    logic             w_emit;
    logic             w_pop;
    logic             w_full;
    logic             w_push;
    logic             w_drop;
    logic [CW-1:0]    w_count_nxt;

    assign w_cfg_change = (nch_active != r_nch) || (decim != r_decim);
    assign w_n          = (r_nch > 4'(NCH)) ? 4'(NCH) : r_nch;
    assign w_k          = FW'(w_n) * FW'(2 * SBITS);
    assign w_keep       = bus.in_valid && (r_dcnt == 4'd0) && (w_k != '0);

    // The accumulator is MSB-aligned: valid bits sit at the top, r_fill of them, zeros below.
    assign w_samp   = ((ACC_W'(bus.in_data) << (ACC_W - KMAX)) & ~({ACC_W{1'b1}} >> w_k)) >> r_fill;
    assign w_merged = r_acc | w_samp;
    assign w_sum    = r_fill + w_k;
    assign w_emit   = (w_sum >= FW'(OUT_W));

    assign w_pop       = r_out_valid && bus.out_ready;
    assign w_full      = (r_count == CW'(DEPTH));
    assign w_push      = r_pend_v && (!w_full || w_pop);
    assign w_drop      = r_pend_v && w_full && !w_pop;
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

    assign bus.out_data  = r_mem[r_rd];
    assign bus.out_valid = r_out_valid;
    assign ovf_count     = r_ovf;
    assign fill_level    = r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_nch       <= nch_active;
            r_decim     <= decim;
            r_dcnt      <= '0;
            r_acc       <= '0;
            r_fill      <= '0;
            r_pend_v    <= 1'b0;
            r_pend_w    <= '0;
            r_wr        <= '0;
            r_rd        <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_ovf       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_pend_v <= 1'b0;
            if (w_cfg_change) begin
                r_nch   <= nch_active;
                r_decim <= decim;
                r_dcnt  <= '0;
                r_acc   <= '0;
                r_fill  <= '0;
            end else if (bus.in_valid) begin
                r_dcnt <= (r_dcnt == r_decim) ? 4'd0 : r_dcnt + 4'd1;
                if (w_keep) begin
                    if (w_emit) begin
                        r_pend_v <= 1'b1;
                        r_pend_w <= w_merged[ACC_W-1 -: OUT_W];
                        r_acc    <= w_merged << OUT_W;
                        r_fill   <= w_sum - FW'(OUT_W);
                    end else begin
                        r_acc  <= w_merged;
                        r_fill <= w_sum;
                    end
                end
            end

            // A completed word enters the FIFO one cycle after it was packed.
            if (w_push) begin
                r_mem[r_wr] <= r_pend_w;
                r_wr        <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            r_count     <= w_count_nxt;
            r_out_valid <= (w_count_nxt != '0);

            if (ovf_clear) begin
                r_ovf <= '0;
            end else if (w_drop && (r_ovf != 16'hFFFF)) begin
                r_ovf <= r_ovf + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_sample_packer.sv
// Directed bench for sample_packer (NCH=4, SBITS=2, OUT_W=16, DEPTH=8): vector table plus
// hand-written latency, decimation, flush, overflow, reset and saturation sequences.
module tb_sample_packer;
    logic        clk;
    logic        reset;
    logic [3:0]  nch_active;
    logic [3:0]  decim;
    logic        ovf_clear;
    logic [15:0] ovf_count;
    logic [3:0]  fill_level;

    int errors;
    int checks;

    typedef struct {
        logic [3:0]        nch;
        logic [0:3][15:0]  s;
        logic [15:0]       exp0;
        int                nwords;
    } vec_t;

    vec_t vecs [6];

    sample_packer_if #(.NCH(4), .SBITS(2), .OUT_W(16)) bus ();

    sample_packer #(.NCH(4), .SBITS(2), .OUT_W(16), .DEPTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .nch_active (nch_active),
        .decim      (decim),
        .ovf_clear  (ovf_clear),
        .ovf_count  (ovf_count),
        .fill_level (fill_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] data);
        bus.in_data  = data;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doReset();
        bus.in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        reset         = 1'b1;
        nch_active    = 4'd2;
        decim         = 4'd0;
        ovf_clear     = 1'b0;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        vecs[0] = '{4'd2, {16'h69AB, 16'hF0CD, 16'h1234, 16'h5678}, 16'h69F0, 2};
        vecs[1] = '{4'd1, {16'hA123, 16'h5FFF, 16'hC000, 16'h3EEE}, 16'hA5C3, 1};
        vecs[2] = '{4'd4, {16'hBEEF, 16'hCAFE, 16'h0001, 16'h8000}, 16'hBEEF, 4};
        vecs[3] = '{4'd0, {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 16'h0000, 0};
        vecs[4] = '{4'd9, {16'h1357, 16'h2468, 16'h0000, 16'hFFFF}, 16'h1357, 4};
        vecs[5] = '{4'd3, {16'hABC0, 16'hDEF0, 16'h1230, 16'h4560}, 16'hABCD, 3};

        doReset();
        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_out_data", 32'(bus.out_data), 32'd0);
        checkOutput("reset_fill", 32'(fill_level), 32'd0);
        checkOutput("reset_ovf", 32'(ovf_count), 32'd0);

        for (int v = 0; v < 6; v++) begin
            nch_active = vecs[v].nch;
            decim      = 4'd0;
            doReset();
            for (int j = 0; j < 4; j++) begin
                applyStimulus(vecs[v].s[j]);
            end
            idle(3);
            checkOutput($sformatf("vec%0d_fill", v), 32'(fill_level), 32'(vecs[v].nwords));
            checkOutput($sformatf("vec%0d_word0", v), 32'(bus.out_data), 32'(vecs[v].exp0));
        end

        // Latency: word completes on the second sample, out_valid two cycles later.
        nch_active = 4'd2;
        doReset();
        applyStimulus(16'h69AB);
        applyStimulus(16'hF0CD);
        checkOutput("lat_valid_early", 32'(bus.out_valid), 32'd0);
        idle(1);
        checkOutput("lat_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("lat_data", 32'(bus.out_data), 32'h69F0);

        // K=12 boundary spanning: ones then zeros, drained in order.
        nch_active = 4'd3;
        doReset();
        for (int j = 0; j < 4; j++) applyStimulus(16'hFFFF);
        for (int j = 0; j < 4; j++) applyStimulus(16'h0000);
        idle(3);
        checkOutput("span_fill", 32'(fill_level), 32'd6);
        bus.out_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            checkOutput($sformatf("span_word%0d", j), 32'(bus.out_data), (j < 3) ? 32'hFFFF : 32'h0000);
            @(posedge clk);
            #1;
        end
        checkOutput("span_empty", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;

        // Decimation by 4: only samples 0 and 4 are packed.
        nch_active = 4'd2;
        decim      = 4'd3;
        doReset();
        for (int j = 0; j < 8; j++) applyStimulus({4'(j), 4'(j), 8'h00});
        idle(3);
        checkOutput("decim_fill", 32'(fill_level), 32'd1);
        checkOutput("decim_word", 32'(bus.out_data), 32'h0044);

        // Overflow: 10 words into 8 slots, then ordered drain.
        nch_active = 4'd4;
        decim      = 4'd0;
        doReset();
        for (int j = 0; j < 10; j++) applyStimulus(16'h1000 + 16'(j));
        idle(3);
        checkOutput("ovf_fill", 32'(fill_level), 32'd8);
        checkOutput("ovf_count", 32'(ovf_count), 32'd2);
        checkOutput("ovf_head", 32'(bus.out_data), 32'h1000);
        bus.out_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            checkOutput($sformatf("drain_word%0d", j), 32'(bus.out_data), 32'h1000 + 32'(j));
            @(posedge clk);
            #1;
        end
        checkOutput("drain_fill", 32'(fill_level), 32'd0);
        bus.out_ready = 1'b0;

        // Config change discards the half word; in_valid on the flush cycle is ignored.
        nch_active = 4'd2;
        doReset();
        applyStimulus(16'hAB00);
        nch_active = 4'd1;
        applyStimulus(16'hFFFF);
        idle(3);
        checkOutput("flush_nothing", 32'(fill_level), 32'd0);
        for (int j = 1; j <= 4; j++) applyStimulus({4'(j), 12'h000});
        idle(3);
        checkOutput("flush_fill", 32'(fill_level), 32'd1);
        checkOutput("flush_word", 32'(bus.out_data), 32'h1234);

        // Reset with a full FIFO and five drops.
        nch_active = 4'd4;
        doReset();
        for (int j = 0; j < 13; j++) applyStimulus(16'h2000 + 16'(j));
        idle(3);
        checkOutput("pre_rst_ovf", 32'(ovf_count), 32'd5);
        checkOutput("pre_rst_fill", 32'(fill_level), 32'd8);
        doReset();
        checkOutput("rst_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_fill", 32'(fill_level), 32'd0);
        checkOutput("rst_ovf", 32'(ovf_count), 32'd0);

        // Long stall saturates the counter; clear wins over a concurrent drop.
        for (int j = 0; j < 65560; j++) applyStimulus(16'h5A5A);
        checkOutput("sat_ovf", 32'(ovf_count), 32'hFFFF);
        ovf_clear = 1'b1;
        applyStimulus(16'h5A5A);
        checkOutput("clear_ovf", 32'(ovf_count), 32'd0);
        ovf_clear = 1'b0;
        applyStimulus(16'h5A5A);
        checkOutput("after_clear_ovf", 32'(ovf_count), 32'd1);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
